// File: rtl/io_display_driver_if.sv
// Bundle of CPU output-port words into the display driver and the digit/status outputs back out.
interface io_display_driver_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in_port0;
  logic [WIDTH-1:0] in_port1;
  logic [WIDTH-1:0] in_port2;
  logic [WIDTH-1:0] in_port3;
  logic [6:0]       hex5;
  logic [6:0]       hex4;
  logic [6:0]       hex3;
  logic [6:0]       hex2;
  logic [6:0]       hex1;
  logic [6:0]       hex0;
  logic             sign_led;
  logic             busy;

  modport master (
    output in_port0, in_port1, in_port2, in_port3,
    input  hex5, hex4, hex3, hex2, hex1, hex0, sign_led, busy
  );

  modport slave (
    input  in_port0, in_port1, in_port2, in_port3,
    output hex5, hex4, hex3, hex2, hex1, hex0, sign_led, busy
  );
endinterface

// File: rtl/io_display_driver.sv
// Shows operand A, operand B and result (0..99) on six active-low 7-segment digits plus sign LED,
// using a three-channel sequential double-dabble converter retriggered by any input change.
module io_display_driver #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic               clock,
  input logic               resetn,
  io_display_driver_if.slave disp
);
  typedef enum logic [1:0] {StIdle, StLoad, StShift, StUpdate} state_e;

  state_e                 r_state, w_state_next;
  logic [3:0][WIDTH-1:0]  r_snap;
  logic                   r_valid;
  logic [2:0]             r_ovf;
  logic [2:0][6:0]        r_bin;
  logic [2:0][7:0]        r_bcd;
  logic [2:0]             r_cnt;
  logic [5:0][6:0]        r_hex;
  logic                   r_sign;

  logic [3:0][WIDTH-1:0]  w_in;
  logic                   w_changed;
  logic [5:0][6:0]        w_hex;

  assign w_in      = {disp.in_port3, disp.in_port2, disp.in_port1, disp.in_port0};
  assign w_changed = (w_in != r_snap);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // One double-dabble step: add-3 correction on each BCD nibble, then shift {bcd, bin} left.
  function automatic logic [14:0] dd_step(input logic [7:0] bcd, input logic [6:0] bin);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return {adj[6:0], bin, 1'b0};
  endfunction

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (!r_valid || w_changed) w_state_next = StLoad;
      StLoad:   w_state_next = StShift;
      StShift:  if (r_cnt == 3'd6) w_state_next = StUpdate;
      StUpdate: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Channel c drives digits 5-2c (tens) and 4-2c (units).
  always_comb begin
    w_hex = '1;
    for (int c = 0; c < 3; c++) begin
      if (r_ovf[c]) begin
        w_hex[5-2*c] = 7'h3F;
        w_hex[4-2*c] = 7'h3F;
      end else begin
        w_hex[5-2*c] = (BLANK_LZ && (r_bcd[c][7:4] == 4'd0)) ? 7'h7F : seg7(r_bcd[c][7:4]);
        w_hex[4-2*c] = seg7(r_bcd[c][3:0]);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_snap  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_hex   <= {6{7'h7F}};
      r_sign  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
        end
        StLoad: begin
          r_snap  <= w_in;
          r_valid <= 1'b1;
          r_cnt   <= '0;
          for (int c = 0; c < 3; c++) begin
            r_ovf[c] <= (w_in[c] > WIDTH'(99));
            r_bin[c] <= w_in[c][6:0];
            r_bcd[c] <= '0;
          end
        end
        StShift: begin
          r_cnt <= r_cnt + 3'd1;
          for (int c = 0; c < 3; c++) begin
            {r_bcd[c], r_bin[c]} <= dd_step(r_bcd[c], r_bin[c]);
          end
        end
        StUpdate: begin
          r_hex  <= w_hex;
          // No "-0": a zero magnitude never lights the sign.
          r_sign <= (r_snap[3] != '0) && (r_snap[2] != '0);
        end
        default: begin
        end
      endcase
    end
  end

  assign disp.hex5     = r_hex[5];
  assign disp.hex4     = r_hex[4];
  assign disp.hex3     = r_hex[3];
  assign disp.hex2     = r_hex[2];
  assign disp.hex1     = r_hex[1];
  assign disp.hex0     = r_hex[0];
  assign disp.sign_led = r_sign;
  assign disp.busy     = (r_state != StIdle);
endmodule

// File: tb/tb_io_display_driver.sv
// Directed bench for io_display_driver: two instances (leading-zero blanking on/off) share stimulus
// and are checked each cycle against a latency-level decimal model plus literal spot checks.
module tb_io_display_driver;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;

  int n_vec = 0;
  int n_err = 0;

  io_display_driver_if #(.WIDTH(32)) u_if_a ();
  io_display_driver_if #(.WIDTH(32)) u_if_b ();

  assign u_if_a.in_port0 = p0;
  assign u_if_a.in_port1 = p1;
  assign u_if_a.in_port2 = p2;
  assign u_if_a.in_port3 = p3;
  assign u_if_b.in_port0 = p0;
  assign u_if_b.in_port1 = p1;
  assign u_if_b.in_port2 = p2;
  assign u_if_b.in_port3 = p3;

  io_display_driver #(.WIDTH(32), .BLANK_LZ(1'b1)) u_dut_a (
    .clock  (clock),
    .resetn (resetn),
    .disp   (u_if_a)
  );

  io_display_driver #(.WIDTH(32), .BLANK_LZ(1'b0)) u_dut_b (
    .clock  (clock),
    .resetn (resetn),
    .disp   (u_if_b)
  );

  always #5 clock = ~clock;

  logic [41:0] hex_a, hex_b;
  assign hex_a = {u_if_a.hex5, u_if_a.hex4, u_if_a.hex3, u_if_a.hex2, u_if_a.hex1, u_if_a.hex0};
  assign hex_b = {u_if_b.hex5, u_if_b.hex4, u_if_b.hex3, u_if_b.hex2, u_if_b.hex1, u_if_b.hex0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference: plain / and % rather than shift-and-add.
  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] chan(input logic [31:0] v, input bit blz);
    int t, u;
    if (v > 32'd99) return {7'h3F, 7'h3F};
    t = int'(v / 32'd10);
    u = int'(v % 32'd10);
    return {(blz && t == 0) ? 7'h7F : seg(t), seg(u)};
  endfunction

  function automatic logic [41:0] model_disp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input bit blz);
    return {chan(a, blz), chan(b, blz), chan(c, blz)};
  endfunction

  // Timing model: change seen in idle -> inputs captured one edge later -> display 9 edges later.
  int          m_phase = 0;
  bit          m_valid = 1'b0;
  logic [31:0] ms0 = '0, ms1 = '0, ms2 = '0, ms3 = '0;
  logic [41:0] exp_a = {6{7'h7F}};
  logic [41:0] exp_b = {6{7'h7F}};
  logic        exp_sign = 1'b0;
  logic        exp_busy;

  assign exp_busy = (m_phase != 0);

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase  <= 0;
      m_valid  <= 1'b0;
      exp_a    <= {6{7'h7F}};
      exp_b    <= {6{7'h7F}};
      exp_sign <= 1'b0;
    end else if (m_phase == 0) begin
      if (!m_valid || ({p3, p2, p1, p0} != {ms3, ms2, ms1, ms0})) m_phase <= 1;
    end else if (m_phase == 1) begin
      ms0     <= p0;
      ms1     <= p1;
      ms2     <= p2;
      ms3     <= p3;
      m_valid <= 1'b1;
      m_phase <= 2;
    end else if (m_phase < 9) begin
      m_phase <= m_phase + 1;
    end else begin
      exp_a    <= model_disp(ms0, ms1, ms2, 1'b1);
      exp_b    <= model_disp(ms0, ms1, ms2, 1'b0);
      exp_sign <= (ms3 != 0) && (ms2 != 0);
      m_phase  <= 0;
    end
  end

  always @(negedge clock) begin
    chk("cmp_hex_a", 64'(hex_a), 64'(exp_a));
    chk("cmp_hex_b", 64'(hex_b), 64'(exp_b));
    chk("cmp_sign_a", 64'(u_if_a.sign_led), 64'(exp_sign));
    chk("cmp_sign_b", 64'(u_if_b.sign_led), 64'(exp_sign));
    chk("cmp_busy_a", 64'(u_if_a.busy), 64'(exp_busy));
    chk("cmp_busy_b", 64'(u_if_b.busy), 64'(exp_busy));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(3);
    chk("reset_hex", 64'(hex_a), 64'({6{7'h7F}}));
    chk("reset_busy", 64'(u_if_a.busy), 64'd0);
    resetn = 1'b1;
    cyc(11);
    chk("zero_hex", 64'(hex_a), 64'({7'h7F, 7'h40, 7'h7F, 7'h40, 7'h7F, 7'h40}));
    chk("zero_sign", 64'(u_if_a.sign_led), 64'd0);
    chk("zero_busy", 64'(u_if_a.busy), 64'd0);

    p0 = 32'd42; p1 = 32'd7; p2 = 32'd35; p3 = 32'd1;
    cyc(9);
    chk("lat_e9_hex0", 64'(u_if_a.hex0), 64'(7'h40));
    chk("lat_e9_busy", 64'(u_if_a.busy), 64'd1);
    cyc(1);
    chk("lat_e10_hex", 64'(hex_a), 64'({7'h19, 7'h24, 7'h7F, 7'h78, 7'h30, 7'h12}));
    chk("lat_e10_sign", 64'(u_if_a.sign_led), 64'd1);
    chk("lat_e10_busy", 64'(u_if_a.busy), 64'd0);

    p2 = 32'd100; p0 = 32'd99;
    cyc(12);
    chk("ovf_hex10", 64'({u_if_a.hex1, u_if_a.hex0}), 64'({7'h3F, 7'h3F}));
    chk("max_hex54", 64'({u_if_a.hex5, u_if_a.hex4}), 64'({7'h10, 7'h10}));
    chk("ovf_sign", 64'(u_if_a.sign_led), 64'd1);
    p2 = 32'hFFFF_FFFF;
    cyc(12);
    chk("ovf_big_hex10", 64'({u_if_a.hex1, u_if_a.hex0}), 64'({7'h3F, 7'h3F}));

    p1 = 32'd5;
    cyc(5);
    p1 = 32'd8;
    cyc(5);
    chk("mid_first_hex2", 64'(u_if_a.hex2), 64'(7'h12));
    cyc(2);
    chk("mid_second_busy", 64'(u_if_a.busy), 64'd1);
    cyc(7);
    chk("mid_hold_hex2", 64'(u_if_a.hex2), 64'(7'h12));
    cyc(1);
    chk("mid_final_hex2", 64'(u_if_a.hex2), 64'(7'h00));
    chk("mid_final_busy", 64'(u_if_a.busy), 64'd0);

    p0 = 32'd17;
    cyc(5);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_hex", 64'(hex_a), 64'({6{7'h7F}}));
    chk("rst_mid_busy", 64'(u_if_a.busy), 64'd0);
    @(posedge clock);
    #1 resetn = 1'b1;
    cyc(12);
    chk("rst_after_hex54", 64'({u_if_a.hex5, u_if_a.hex4}), 64'({7'h79, 7'h78}));
    chk("rst_after_busy", 64'(u_if_a.busy), 64'd0);

    p2 = 32'd0;
    cyc(12);
    chk("negzero_sign", 64'(u_if_a.sign_led), 64'd0);
    chk("negzero_hex10", 64'({u_if_a.hex1, u_if_a.hex0}), 64'({7'h7F, 7'h40}));

    p0 = 32'd3;
    cyc(12);
    chk("nolz_hex54", 64'({u_if_b.hex5, u_if_b.hex4}), 64'({7'h40, 7'h30}));
    chk("lz_hex54", 64'({u_if_a.hex5, u_if_a.hex4}), 64'({7'h7F, 7'h30}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/io_display_driver.md
Name: io_display_driver

Overview:
- Downstream consumer of the memory-mapped output ports of the pipelined CPU I/O subsystem. It takes the four registered output words (operand A, operand B, result magnitude, result sign) and shows them on six active-low 7-segment digits plus a sign LED.
- Conversion is a sequential double-dabble binary-to-BCD engine that runs all three channels in parallel. The engine starts whenever any input differs from the last converted snapshot.

Parameters:
- WIDTH, 32, width of each input port word.
- BLANK_LZ, 1, when 1 a tens digit of 0 is shown blank; when 0 it is shown as "0".

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_port0  input  WIDTH  operand A word (CPU address 80h).
- in_port1  input  WIDTH  operand B word (CPU address 84h).
- in_port2  input  WIDTH  result magnitude (CPU address 88h, already absolute).
- in_port3  input  WIDTH  result sign flag; nonzero means negative.
- hex5, hex4  output  7  operand A tens/units, active-low gfedcba.
- hex3, hex2  output  7  operand B tens/units.
- hex1, hex0  output  7  result tens/units.
- sign_led  output  1  1 = result negative.
- busy  output  1  1 while a conversion is in progress.

Behaviour:
- Reset (async, resetn=0):
  - All hex outputs = 7'h7F (blank).
  - sign_led=0, busy=0, state=IDLE.
  - Snapshot registers = 0, with a "valid" flag cleared so the first post-reset cycle always triggers a conversion.
  - Reset asserted mid-conversion aborts the conversion immediately; no partial update is ever visible.
- FSM states: IDLE, LOAD, SHIFT, UPDATE.
  - IDLE: if the valid flag is clear, or any of in_port0..3 differs from the snapshot, go to LOAD; otherwise stay.
  - LOAD: copy all four inputs into the snapshot and set valid. Per channel:
    - overflow flag = (snapshot value > 99, full WIDTH unsigned compare).
    - Load the low 7 bits into a shift register.
    - Clear an 8-bit BCD accumulator.
    - Clear a 3-bit counter.
    - Go to SHIFT.
  - SHIFT: once per cycle, for each channel:
    - For each BCD nibble >= 5, add 3.
    - Shift {bcd, bin} left by 1.
    - Counter increments.
    - After the 7th shift (counter == 6 at the edge), go to UPDATE.
  - UPDATE: register the segment codes into the hex outputs, set sign_led = (snapshot port3 != 0) && (snapshot port2 != 0), then go to IDLE.
- busy = (state != IDLE).
- Latency: inputs change at edge 0 -> LOAD at edge 1, capture at edge 2, shifts at edges 3..9, outputs change at edge 10. busy is high from edge 1 to edge 10.
- Inputs changing during SHIFT/UPDATE are ignored for the current conversion. On return to IDLE the compare against the snapshot triggers a fresh conversion, so the final display always matches the final stable inputs.
- Hex outputs change only in UPDATE and never glitch between conversions.
- Segment codes (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - blank=7F, dash=3F.
- Overflow channel: both digits show dash. sign_led is still driven from port3.
- BLANK_LZ=1 and tens=0: tens digit is blank; the units digit is always shown, so 0 displays as " 0".
- Sign is shown only on sign_led, never as a segment minus. Port3 nonzero with port2 = 0 gives sign_led=0 (no "-0").

Test Plan:
- Reset then release with all inputs 0 -> after 11 edges: hex5..hex0 = 7F,40,7F,40,7F,40; sign_led=0; busy back to 0.
- port0=42, port1=7, port2=35, port3=1 -> hex5/4 = 19/24; hex3/2 = 7F/78; hex1/0 = 30/12; sign_led=1; update exactly at edge 10 after the change.
- port2=100, port0=99 -> hex1/0 = 3F/3F; hex5/4 = 10/10; port2=32'hFFFFFFFF also gives dashes.
- Change port1 from 5 to 8 at the 4th SHIFT cycle -> first UPDATE shows 5 (hex2=12); a second conversion follows and the final hex2=00; busy drops only after the second UPDATE.
- Assert resetn=0 mid-SHIFT -> outputs go to 7F and busy to 0 asynchronously; after release, a full conversion of the current inputs occurs.
- port3=1, port2=0 -> sign_led=0, hex1/0 = 7F/40. With BLANK_LZ=0 and port0=3 -> hex5/4 = 40/30.
